// File: rtl/fixed_point_subtractor.sv
// fixed_point_subtractor: sequential saturating two's-complement A-B with clamp-event counter
module fixed_point_subtractor #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 clear_count,
  output logic [WIDTH-1:0]     diff,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] sat_count
);
  typedef enum logic [1:0] {IDLE, SUB, CLAMP} state_t;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_t               state_q, state_d;
  logic [WIDTH:0]       temp_q, temp_d;
  logic [WIDTH-1:0]     diff_q, diff_d;
  logic                 done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, sat_pos, sat_neg;
  assign accept  = enable && (state_q == IDLE || state_q == CLAMP);
  assign sat_pos = temp_q[WIDTH:WIDTH-1] == 2'b01;
  assign sat_neg = temp_q[WIDTH:WIDTH-1] == 2'b10;
  assign diff      = diff_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign sat_count = cnt_q;
  // State register; an in-flight op is simply dropped on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Next state: new ops are only taken in IDLE or on the CLAMP cycle
  always_comb begin
    state_d = accept ? SUB : (state_q == SUB) ? CLAMP : IDLE;
  end
  // Next values of the registered outputs and the exact (WIDTH+1)-bit difference
  always_comb begin
    temp_d = accept ? {A[WIDTH-1], A} - {B[WIDTH-1], B} : temp_q;
    diff_d = (state_q != SUB) ? diff_q : sat_pos ? MAX_POS : sat_neg ? MIN_NEG : temp_q[WIDTH-1:0];
    ovf_d  = (state_q == SUB) ? (sat_pos || sat_neg) : ovf_q;
    done_d = state_q == SUB;
    busy_d = state_d == SUB;
    cnt_d  = clear_count ? '0 : (done_d && ovf_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temp_q <= '0;
      diff_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      temp_q <= temp_d;
      diff_q <= diff_d;
      done_q <= done_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fixed_point_subtractor.sv
// tb_fixed_point_subtractor: directed and random checks of the saturating subtractor
module tb_fixed_point_subtractor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        clear_count = 1'b0;
  logic [15:0] diff;
  logic        done, busy, overflow;
  logic [7:0]  sat_count;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  fixed_point_subtractor #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .A(A), .B(B), .clear_count(clear_count),
    .diff(diff), .done(done), .busy(busy), .overflow(overflow), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = $signed(a) - $signed(b);
    if (d > 32767) return {1'b1, 16'h7FFF};
    if (d < -32768) return {1'b1, 16'h8000};
    return {1'b0, d[15:0]};
  endfunction

  // single op: enable for one edge, then sample after the result edge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a; B = b; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    A = ~a; B = ~b;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [15:0] pd [4];
    logic [16:0] r;
    logic [15:0] ra, rb;
    #2 reset = 1'b0;
    #20 reset = 1'b1;
    @(negedge clk);
    chk("rst_diff", diff, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", sat_count, 0);

    do_op(16'h1000, 16'h0800);
    chk("t1_done", done, 1);
    chk("t1_diff", diff, 16'h0800);
    chk("t1_ovf", overflow, 0);
    @(negedge clk);
    chk("t1_done_drop", done, 0);
    chk("t1_diff_hold", diff, 16'h0800);

    do_op(16'h8000, 16'h0001);
    chk("t2a_diff", diff, 16'h8000);
    chk("t2a_ovf", overflow, 1);
    chk("t2a_cnt", sat_count, 1);
    do_op(16'h0000, 16'h8000);
    chk("t2b_diff", diff, 16'h7FFF);
    chk("t2b_ovf", overflow, 1);
    chk("t2b_cnt", sat_count, 2);
    do_op(16'h7FFF, 16'hFFFF);
    chk("t2c_diff", diff, 16'h7FFF);
    chk("t2c_cnt", sat_count, 3);
    do_op(16'hFFFF, 16'h7FFF);
    chk("t2d_diff", diff, 16'h8000);
    chk("t2d_ovf", overflow, 0);

    pa = '{16'h0005, 16'hFFF0, 16'h4000, 16'h0100};
    pb = '{16'h0003, 16'h0010, 16'hC000, 16'h0200};
    pd = '{16'h0002, 16'hFFE0, 16'h7FFF, 16'hFF00};
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A = pa[i]; B = pb[i];
      @(negedge clk);
      chk("t3_busy", busy, 1);
      chk("t3_done_low", done, 0);
      A = 16'h1234; B = 16'h4321;
      @(negedge clk);
      chk("t3_done", done, 1);
      chk("t3_diff", diff, pd[i]);
    end
    enable = 1'b0;
    @(negedge clk);
    chk("t3_idle_done", done, 0);
    chk("t3_idle_busy", busy, 0);
    A = 16'h0009; B = 16'h0004; enable = 1'b1;
    @(negedge clk);
    A = 16'h0000; B = 16'h0001;
    @(negedge clk);
    enable = 1'b0;
    chk("t3_pulse_done", done, 1);
    chk("t3_pulse_diff", diff, 16'h0005);
    @(negedge clk);
    chk("t3_pulse_nodone", done, 0);
    chk("t3_pulse_nobusy", busy, 0);

    A = 16'h8000; B = 16'h0001; enable = 1'b1;
    for (int i = 0; i < 600; i++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t4_cnt_stick", sat_count, 8'hFF);
    @(negedge clk);
    A = 16'h8000; B = 16'h7FFF; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    chk("t4_clear_ovf", overflow, 1);
    chk("t4_clear_wins", sat_count, 0);

    do_op(16'h0000, 16'h8000);
    @(negedge clk);
    A = 16'h0010; B = 16'h0001; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("t5_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_diff", diff, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_cnt", sat_count, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_done", done, 0);
    end

    exp_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      r = ref_sub(ra, rb);
      do_op(ra, rb);
      if (r[16] && exp_cnt < 255) exp_cnt++;
      chk("rnd_done", done, 1);
      chk("rnd_diff", diff, r[15:0]);
      chk("rnd_ovf", overflow, r[16]);
      chk("rnd_cnt", sat_count, exp_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
